// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
// The opcode constants are also used by the control unit.
package fetch_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 7;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        ERROR
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack, control-unit valid/ready and redirect.
// The master modport is the fetch unit; the slave modport is memory plus control unit.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 64
);
    import fetch_pkg::*;

    logic                fetch_en;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack;
    logic [INSTR_W-1:0]  mem_rdata;
    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instrucao;
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   instr_pc;
    logic                pc_load;
    logic [ADDR_W-1:0]   pc_target;
    logic [ADDR_W-1:0]   pc;
    logic                fetch_err;
    logic                err_clr;

    modport master (
        input  fetch_en, mem_ack, mem_rdata, instr_ready, pc_load, pc_target, err_clr,
        output mem_req, mem_addr, instr_valid, instrucao, opcode, instr_pc, pc, fetch_err
    );

    modport slave (
        output fetch_en, mem_ack, mem_rdata, instr_ready, pc_load, pc_target, err_clr,
        input  mem_req, mem_addr, instr_valid, instrucao, opcode, instr_pc, pc, fetch_err
    );

endinterface

// File: rtl/instr_fetch_unit_wdog.sv
// Fetch watchdog: counts unacknowledged request cycles and flags the last allowed one.
module fetch_wdog #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire_c
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Asserted in the cycle whose increment would reach MAX_WAIT.
    assign expire_c = en && (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory, holds the instruction for the
// control unit and applies branch/jump redirects.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   bus
);

    fetch_state_t       state, state_d;
    logic [ADDR_W-1:0]  pc, pc_d;
    logic [ADDR_W-1:0]  mem_addr;
    logic [ADDR_W-1:0]  instr_pc;
    logic [INSTR_W-1:0] instrucao;
    logic               squash, squash_d;
    logic               mem_req, instr_valid, fetch_err;
    logic               load_instr;
    logic               redirect_ok, redirect_bad;
    logic               wd_en, wd_clr, wd_expire_c;

    assign redirect_ok  = bus.pc_load && (bus.pc_target[1:0] == 2'b00);
    assign redirect_bad = bus.pc_load && (bus.pc_target[1:0] != 2'b00);
    assign wd_en        = (state == REQ) && !bus.mem_ack;
    assign wd_clr       = (state_d != REQ);

    fetch_wdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (wd_en),
        .clr      (wd_clr),
        .expire_c (wd_expire_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        squash_d   = squash;
        load_instr = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_bad) begin
                    state_d = ERROR;
                end else begin
                    if (redirect_ok) pc_d = bus.pc_target;
                    if (bus.fetch_en) state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_bad) begin
                    state_d = ERROR;
                end else if (bus.mem_ack) begin
                    // A redirect seen now or earlier in this request makes the data stale.
                    if (squash || redirect_ok) begin
                        if (redirect_ok) pc_d = bus.pc_target;
                        state_d = IDLE;
                    end else begin
                        load_instr = 1'b1;
                        pc_d       = pc + ADDR_W'(4);
                        state_d    = HOLD;
                    end
                end else begin
                    if (redirect_ok) begin
                        pc_d     = bus.pc_target;
                        squash_d = 1'b1;
                    end
                    if (wd_expire_c) state_d = ERROR;
                end
            end
            HOLD: begin
                if (redirect_bad) begin
                    state_d = ERROR;
                end else if (redirect_ok || bus.instr_ready) begin
                    if (redirect_ok) pc_d = bus.pc_target;
                    state_d = bus.fetch_en ? REQ : IDLE;
                end
            end
            ERROR: begin
                if (bus.err_clr) state_d = IDLE;
            end
        endcase
        if (state_d != REQ) squash_d = 1'b0;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            squash      <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            instrucao   <= NOP_INSTR;
            instr_pc    <= '0;
        end else begin
            pc          <= pc_d;
            squash      <= squash_d;
            mem_req     <= (state_d == REQ);
            instr_valid <= (state_d == HOLD);
            fetch_err   <= (state_d == ERROR);
            // Address is frozen for the whole request, even across a redirect.
            if ((state_d == REQ) && (state != REQ)) mem_addr <= pc_d;
            if (load_instr) begin
                instrucao <= bus.mem_rdata;
                instr_pc  <= pc;
            end
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = mem_addr;
    assign bus.instr_valid = instr_valid;
    assign bus.instrucao   = instrucao;
    assign bus.opcode      = instrucao[OPCODE_W-1:0];
    assign bus.instr_pc    = instr_pc;
    assign bus.pc          = pc;
    assign bus.fetch_err   = fetch_err;

endmodule
